// File: rtl/systolic_feeder_pkg.sv
// Shared defaults and FSM state type for the systolic array feeder.
package systolic_feeder_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned VEC_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Weight-row and activation-vector valid/ready channels into the feeder.
interface systolic_feeder_if import systolic_feeder_pkg::*; #(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          w_valid;
  logic          w_ready;
  logic [N*DW-1:0] w_data;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] in_data;

  modport master (output w_valid, w_data, in_valid, in_data,
                  input  w_ready, in_ready);
  modport slave  (input  w_valid, w_data, in_valid, in_data,
                  output w_ready, in_ready);

endinterface

// File: rtl/systolic_feeder_skew_delay_line.sv
// Clearable DEPTH-stage shift register that advances only when enabled.
module skew_delay_line import systolic_feeder_pkg::*; #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] taps [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (enable) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Loads N weight rows into a systolic array, then streams K skewed activation
// vectors followed by 2N-1 zero vectors to flush the array.
module systolic_feeder import systolic_feeder_pkg::*; #(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [VEC_CNT_W-1:0] num_vectors,
  systolic_feeder_if.slave     bus,
  output logic [N*DW-1:0]      weight_bus,
  output logic [N-1:0]         load_weight,
  output logic [N*DW-1:0]      a_row,
  output logic                 pe_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned ROW_W      = $clog2(N);
  localparam int unsigned DRAIN_W    = $clog2(2*N);
  localparam int unsigned DRAIN_LAST = 2*N - 2;

  state_t               state, state_next;
  logic [ROW_W-1:0]     row_cnt;
  logic [VEC_CNT_W-1:0] vec_cnt, k_reg;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 w_accept, in_accept, step, clear_skew, done_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.w_ready  = 1'b0;
    bus.in_ready = 1'b0;
    w_accept     = 1'b0;
    in_accept    = 1'b0;
    step         = 1'b0;
    clear_skew   = 1'b0;
    done_set     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_vectors != '0) begin
            state_next = LOAD_W;
            clear_skew = 1'b1;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      LOAD_W: begin
        bus.w_ready = 1'b1;
        w_accept    = bus.w_valid;
        if (w_accept && row_cnt == ROW_W'(N-1)) state_next = STREAM;
      end
      STREAM: begin
        bus.in_ready = (vec_cnt < k_reg);
        in_accept    = bus.in_valid && bus.in_ready;
        step         = in_accept;
        if (in_accept && vec_cnt == k_reg - VEC_CNT_W'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        step = 1'b1;
        if (drain_cnt == DRAIN_W'(DRAIN_LAST)) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Job counters; all restart when a job is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt   <= '0;
      vec_cnt   <= '0;
      k_reg     <= '0;
      drain_cnt <= '0;
    end else if (clear_skew) begin
      row_cnt   <= '0;
      vec_cnt   <= '0;
      k_reg     <= num_vectors;
      drain_cnt <= '0;
    end else begin
      if (w_accept)
        row_cnt <= (row_cnt == ROW_W'(N-1)) ? '0 : row_cnt + ROW_W'(1);
      if (in_accept)
        vec_cnt <= vec_cnt + VEC_CNT_W'(1);
      if (state == DRAIN)
        drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_bus  <= '0;
      load_weight <= '0;
      pe_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      load_weight <= '0;
      if (w_accept) begin
        weight_bus  <= bus.w_data;
        load_weight <= N'(1) << row_cnt;
      end
      pe_valid <= step;
      busy     <= (state_next != IDLE);
      done     <= done_set;
    end
  end

  // Lane i is delayed i+1 steps; zeros are injected while draining.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] lane_in;
    assign lane_in = (state == STREAM) ? bus.in_data[DW*i +: DW] : '0;
    skew_delay_line #(.DEPTH(i + 1), .DW(DW)) u_skew (
      .clk    (clk),
      .reset  (reset),
      .enable (step),
      .clear  (clear_skew),
      .din    (lane_in),
      .dout   (a_row[DW*i +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder against a per-step skew model.
module tb_systolic_feeder;
  import systolic_feeder_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned NW = N*DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    num_vectors;
  logic [NW-1:0] weight_bus, a_row;
  logic [N-1:0]  load_weight;
  logic          pe_valid, busy, done;

  systolic_feeder_if #(.N(N), .DW(DW)) bus ();

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_vectors (num_vectors),
    .bus         (bus),
    .weight_bus  (weight_bus),
    .load_weight (load_weight),
    .a_row       (a_row),
    .pe_valid    (pe_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [NW-1:0] w_rows [N];
  logic [NW-1:0] vecs [$];

  function automatic logic [NW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [NW-1:0] r;
    r = {DW'(d), DW'(c), DW'(b), DW'(a)};
    return r;
  endfunction

  function automatic logic [NW-1:0] junk();
    return NW'({$urandom, $urandom});
  endfunction

  // Step s presents row i of vector s-i on lane i, zero outside the job's vectors.
  function automatic logic [NW-1:0] exp_arow(input int s, input int k);
    logic [NW-1:0] r, v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (s - i >= 0 && s - i < k) begin
        v = vecs[s-i];
        r[DW*i +: DW] = v[DW*i +: DW];
      end
    end
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    checks++; if (weight_bus !== '0) $display("FAIL %s weight_bus got %h want 0", tag, weight_bus); else passed++;
    checks++; if (load_weight !== '0) $display("FAIL %s load_weight got %b want 0", tag, load_weight); else passed++;
    checks++; if (a_row !== '0) $display("FAIL %s a_row got %h want 0", tag, a_row); else passed++;
    checks++; if (pe_valid !== 1'b0) $display("FAIL %s pe_valid got %b want 0", tag, pe_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL %s busy got %b want 0", tag, busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL %s done got %b want 0", tag, done); else passed++;
    checks++; if (bus.w_ready !== 1'b0) $display("FAIL %s w_ready got %b want 0", tag, bus.w_ready); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL %s in_ready got %b want 0", tag, bus.in_ready); else passed++;
  endtask

  // mode 0: always valid, 1: random valid gaps, 2: two idle cycles after first vector.
  task automatic run_job(input int k, input int mode, input bit abort);
    int acc_n, pv_n, lows, gaps;
    bit acc, done_seen;
    logic [N-1:0]  exp_lw;
    logic [NW-1:0] prev;

    num_vectors = 8'(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL busy_on_start got %b want 1", busy); else passed++;

    for (int r = 0; r < N; r++) begin
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
        bus.w_valid = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.w_data  = bus.w_valid ? w_rows[r] : junk();
        checks++; if (bus.w_ready !== 1'b1) $display("FAIL w_ready_load row %0d got %b want 1", r, bus.w_ready); else passed++;
        acc = bus.w_valid && bus.w_ready;
        @(posedge clk); #1;
        exp_lw = '0;
        if (acc) exp_lw[r] = 1'b1;
        checks++; if (load_weight !== exp_lw) $display("FAIL load_weight row %0d got %b want %b", r, load_weight, exp_lw); else passed++;
        if (acc) begin
          checks++; if (weight_bus !== w_rows[r]) $display("FAIL weight_bus row %0d got %h want %h", r, weight_bus, w_rows[r]); else passed++;
        end
      end
      if (!acc) begin
        checks++;
        $display("FAIL weight_beat_timeout row %0d got no accept want accept", r);
        bus.w_valid = 1'b0;
        return;
      end
    end
    bus.w_valid = 1'b0;

    acc_n = 0; pv_n = 0; lows = 0; gaps = 0; done_seen = 1'b0;
    prev = a_row;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      if (acc_n < k) begin
        if (mode == 1)                                bus.in_valid = ($urandom_range(0, 3) != 0);
        else if (mode == 2 && acc_n == 1 && gaps < 2) begin bus.in_valid = 1'b0; gaps++; end
        else                                          bus.in_valid = 1'b1;
        bus.in_data = bus.in_valid ? vecs[acc_n] : junk();
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = junk();
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL in_ready_after_k got %b want 0", bus.in_ready); else passed++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) acc_n++;
      @(posedge clk); #1;
      if (pe_valid === 1'b1) begin
        checks++; if (a_row !== exp_arow(pv_n, k)) $display("FAIL a_row step %0d got %h want %h", pv_n, a_row, exp_arow(pv_n, k)); else passed++;
        pv_n++;
      end else begin
        lows++;
        checks++; if (a_row !== prev) $display("FAIL a_row_frozen got %h want %h", a_row, prev); else passed++;
      end
      checks++; if (load_weight !== '0) $display("FAIL load_weight_stream got %b want 0", load_weight); else passed++;
      checks++; if (busy !== !done) $display("FAIL busy_vs_done busy %b done %b want busy=!done", busy, done); else passed++;
      if (done === 1'b1) begin
        done_seen = 1'b1;
        checks++; if (pv_n !== k + 2*N - 1) $display("FAIL done_step got %0d want %0d", pv_n, k + 2*N - 1); else passed++;
      end
      prev = a_row;
      if (abort && acc_n == k && pv_n == k + 2) begin
        #2 reset = 1'b1;
        #1 check_all_zero("reset_in_drain");
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;

    checks++; if (!done_seen) $display("FAIL done_seen got 0 want 1"); else passed++;
    if (mode != 1) begin
      checks++; if (lows !== ((mode == 2) ? 2 : 0)) $display("FAIL stall_cycles got %0d want %0d", lows, (mode == 2) ? 2 : 0); else passed++;
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL done_pulse_width got %b want 0", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL busy_after_job got %b want 0", busy); else passed++;
    checks++; if (pe_valid !== 1'b0) $display("FAIL pe_valid_after_job got %b want 0", pe_valid); else passed++;
    checks++; if (a_row !== '0) $display("FAIL a_row_flushed got %h want 0", a_row); else passed++;
  endtask

  task automatic load_directed();
    for (int r = 0; r < N; r++) w_rows[r] = pack4(r + 1, r + 1, r + 1, r + 1);
    vecs.delete();
    vecs.push_back(pack4(1, 2, 3, 4));
    vecs.push_back(pack4(5, 6, 7, 8));
    vecs.push_back(pack4(9, 10, 11, 12));
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_vectors = '0;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("idle_after_reset");
  endtask

  task automatic test_directed();
    load_directed();
    run_job(3, 0, 1'b0);
  endtask

  task automatic test_stall();
    load_directed();
    run_job(3, 2, 1'b0);
  endtask

  task automatic test_k_zero();
    num_vectors = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (done !== 1'b1) $display("FAIL k0_done got %b want 1", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL k0_busy got %b want 0", busy); else passed++;
    checks++; if (bus.w_ready !== 1'b0) $display("FAIL k0_w_ready got %b want 0", bus.w_ready); else passed++;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) $display("FAIL k0_done_clear got %b want 0", done); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL k0_busy_idle got %b want 0", busy); else passed++;
      checks++; if (load_weight !== '0) $display("FAIL k0_load_weight got %b want 0", load_weight); else passed++;
    end
  endtask

  task automatic test_reset_in_drain();
    for (int r = 0; r < N; r++) w_rows[r] = junk() | NW'(1);
    vecs.delete();
    for (int v = 0; v < 3; v++) vecs.push_back(junk());
    run_job(3, 0, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) $display("FAIL no_autostart busy got %b want 0", busy); else passed++;
      checks++; if (bus.w_ready !== 1'b0) $display("FAIL no_autostart w_ready got %b want 0", bus.w_ready); else passed++;
    end
    load_directed();
    vecs.delete();
    vecs.push_back(pack4(1, 2, 3, 4));
    run_job(1, 0, 1'b0);
  endtask

  task automatic test_random();
    int k;
    for (int j = 0; j < 6; j++) begin
      k = (j == 5) ? 20 : int'($urandom_range(1, 6));
      for (int r = 0; r < N; r++) w_rows[r] = junk();
      vecs.delete();
      for (int v = 0; v < k; v++) vecs.push_back(junk());
      run_job(k, 1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_k_zero();
    test_reset_in_drain();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
